mutual_rule_scheduler: RTL

//   Upstream stage of the mutual-exclusion `system` block: drives its io_en_a rule-enable vector.

---
 rtl/mutual_rule_scheduler_if.sv | 30 +++
 rtl/mutual_rule_scheduler.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mutual_rule_scheduler_if.sv
// Bundle between the rule scheduler and the mutual-exclusion system block.
// There is no valid/ready pair here: io_guard/io_pause are sampled on every
// clock edge, and io_en_a is a one-cycle enable strobe that the system must
// act on during the cycle it is shown (io_fire marks a non-zero io_en_a).
interface mutual_rule_scheduler_if #(
    parameter int NUM_RULES = 4,
    parameter int IDX_W     = 2,
    parameter int CNT_W     = 4
);
    logic [NUM_RULES-1:0] io_guard;
    logic                 io_pause;
    logic [NUM_RULES-1:0] io_en_a;
    logic                 io_fire;
    logic [IDX_W-1:0]     io_rule_idx;
    logic [NUM_RULES-1:0] io_starve;
    logic [CNT_W-1:0]     io_fire_count;
    logic [1:0]           dbg_state;

    // Scheduler side
    modport master (
        input  io_guard, io_pause,
        output io_en_a, io_fire, io_rule_idx, io_starve, io_fire_count, dbg_state
    );

    // System / environment side
    modport slave (
        output io_guard, io_pause,
        input  io_en_a, io_fire, io_rule_idx, io_starve, io_fire_count, dbg_state
    );
endinterface

// File: rtl/mutual_rule_scheduler.sv
// Round-robin, one-hot rule issuer for the mutual-exclusion system block.
// Grants at most one rule per edge from the guard-true flags, with a
// post-reset flush, a pause mode, per-rule starvation flags and a wrapping
// grant counter. All outputs are registered.
module mutual_rule_scheduler #(
    parameter int NUM_RULES    = 4,
    parameter int IDX_W        = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    mutual_rule_scheduler_if.master bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [FW-1:0]        FLUSH_LAST  = FW'(FLUSH_CYCLES - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(NUM_RULES - 1);
    localparam logic [IDX_W:0]       NUM_RULES_W = (IDX_W + 1)'(NUM_RULES);
    localparam logic [CW-1:0]        LIMIT_W     = CW'(STARVE_LIMIT);
    localparam logic [NUM_RULES-1:0] ONE_HOT0    = NUM_RULES'(1);

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t               state_q;
    logic [FW-1:0]        flush_cnt_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [NUM_RULES-1:0] en_q;
    logic                 fire_q;
    logic [IDX_W-1:0]     idx_q;
    logic [CNT_W-1:0]     count_q;
    logic [CW-1:0]        wait_q [NUM_RULES];
    logic [CW-1:0]        wait_d [NUM_RULES];
    logic [NUM_RULES-1:0] starve_q;
    logic [NUM_RULES-1:0] starve_d;

    logic [NUM_RULES-1:0] rot_guard;
    logic                 found;
    logic [IDX_W:0]       off;
    logic [IDX_W:0]       sum;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     ptr_nxt;
    logic                 grant_now;
    logic [NUM_RULES-1:0] grant_vec;

    // Round-robin pick: rotate guards so ptr sits at bit 0, take lowest set bit
    always_comb begin
        rot_guard = (bus.io_guard >> ptr_q) | (bus.io_guard << (NUM_RULES - int'(ptr_q)));
        found     = 1'b0;
        off       = '0;
        for (int k = NUM_RULES - 1; k >= 0; k--) begin
            if (rot_guard[k]) begin
                found = 1'b1;
                off   = (IDX_W + 1)'(k);
            end
        end
        sum = {1'b0, ptr_q} + off;
        if (sum >= NUM_RULES_W) begin
            sum = sum - NUM_RULES_W;
        end
        grant_idx = sum[IDX_W-1:0];
        ptr_nxt   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        grant_now = (state_q == ST_RUN) && !bus.io_pause && found;
        grant_vec = grant_now ? (ONE_HOT0 << grant_idx) : '0;
    end

    // Control FSM with registered grant outputs; enables default to zero each edge
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= '0;
            ptr_q       <= '0;
            en_q        <= '0;
            fire_q      <= 1'b0;
            idx_q       <= '0;
            count_q     <= '0;
        end else begin
            en_q   <= '0;
            fire_q <= 1'b0;
            case (state_q)
                ST_FLUSH: begin
                    flush_cnt_q <= flush_cnt_q + 1'b1;
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.io_pause) begin
                        state_q <= ST_PAUSE;
                    end else if (found) begin
                        en_q    <= grant_vec;
                        fire_q  <= 1'b1;
                        idx_q   <= grant_idx;
                        ptr_q   <= ptr_nxt;
                        count_q <= count_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    // Resume only re-enters RUN; the first grant comes one edge later
                    if (!bus.io_pause) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_FLUSH;
            endcase
        end
    end

    // Per-rule wait counters: clear on grant or false guard, else saturate at the limit
    always_comb begin
        for (int i = 0; i < NUM_RULES; i++) begin
            if (grant_vec[i] || !bus.io_guard[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] == LIMIT_W) begin
                wait_d[i] = wait_q[i];
            end else begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
            starve_d[i] = (wait_d[i] == LIMIT_W);
        end
    end

    // Wait counter and starvation flag registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                wait_q[i] <= '0;
            end
            starve_q <= '0;
        end else begin
            for (int i = 0; i < NUM_RULES; i++) begin
                wait_q[i] <= wait_d[i];
            end
            starve_q <= starve_d;
        end
    end

    assign bus.io_en_a       = en_q;
    assign bus.io_fire       = fire_q;
    assign bus.io_rule_idx   = idx_q;
    assign bus.io_starve     = starve_q;
    assign bus.io_fire_count = count_q;
    assign bus.dbg_state     = state_q;

endmodule
